// File: rtl/placement_search.sv
// Sweeps every (column, rotation) candidate for a falling block through an external
// simulator and evaluator, and reports the lowest-scoring legal placement.
module placement_search #(
  parameter int COLS           = 10,
  parameter int ROWS           = 20,
  parameter int COL_W          = 4,
  parameter int CLR_W          = 10,
  parameter int SCORE_W        = 64,
  parameter bit SKIP_SYMMETRIC = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_to_client,
  input  logic [3:0]                cur_block,
  input  logic [ROWS*COLS-1:0]      cur_board,
  output logic                      resp_from_client,
  output logic [COL_W-1:0]          opt_col,
  output logic [1:0]                opt_rotation,
  output logic                      opt_found,
  output logic signed [SCORE_W-1:0] opt_score,
  output logic                      sim_request,
  output logic [COL_W-1:0]          sim_col,
  output logic [1:0]                sim_rotation,
  output logic [3:0]                sim_block,
  output logic [ROWS*COLS-1:0]      sim_board,
  input  logic                      sim_ready,
  input  logic                      sim_valid,
  input  logic [ROWS*COLS-1:0]      sim_next_board,
  input  logic [CLR_W-1:0]          sim_cleared,
  output logic                      eval_request,
  output logic [ROWS*COLS-1:0]      eval_board,
  output logic [CLR_W-1:0]          eval_cleared,
  input  logic                      eval_ready,
  input  logic signed [SCORE_W-1:0] eval_score
);

  localparam int BW = ROWS * COLS;
  localparam logic signed [SCORE_W-1:0] SCORE_MAX = {1'b0, {(SCORE_W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, SIM, EVAL, RESP} state_t;

  state_t                      state, state_next;
  logic [COL_W-1:0]            col;
  logic [1:0]                  rot;
  logic [3:0]                  blk;
  logic [BW-1:0]               board;
  logic signed [SCORE_W-1:0]   best;
  logic                        found;

  logic [1:0] rot_last;
  logic       at_rot_last;
  logic       at_col_last;
  logic       accept;
  logic       sim_done;
  logic       eval_done;
  logic       advance;
  logic       better;

  // Last rotation index to try: symmetric blocks repeat their shape after NROT turns.
  always_comb begin
    rot_last = 2'd3;
    if (SKIP_SYMMETRIC) begin
      unique case (blk)
        4'd1:                rot_last = 2'd0;
        4'd0, 4'd3, 4'd4:    rot_last = 2'd1;
        default:             rot_last = 2'd3;
      endcase
    end
  end

  assign at_rot_last = (rot == rot_last);
  assign at_col_last = (col == COL_W'(COLS - 1));

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    sim_done   = 1'b0;
    eval_done  = 1'b0;
    advance    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_to_client) begin
          accept     = 1'b1;
          state_next = (cur_block < 4'd7) ? SIM : RESP;
        end
      end
      SIM: begin
        if (sim_ready) begin
          sim_done = 1'b1;
          if (sim_valid) state_next = EVAL;
          else           advance    = 1'b1;
        end
      end
      EVAL: begin
        if (eval_ready) begin
          eval_done = 1'b1;
          advance   = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (advance) state_next = (at_rot_last && at_col_last) ? RESP : SIM;
  end

  // Strict compare keeps the earliest candidate on ties.
  assign better = eval_done && (eval_score < best);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the latched boards are reset too, because their reset value is visible on output ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      rot          <= '0;
      blk          <= '0;
      board        <= '0;
      best         <= '0;
      found        <= 1'b0;
      eval_board   <= '0;
      eval_cleared <= '0;
      opt_col      <= '0;
      opt_rotation <= '0;
      opt_found    <= 1'b0;
      opt_score    <= '0;
    end else begin
      if (accept) begin
        blk          <= cur_block;
        board        <= cur_board;
        col          <= '0;
        rot          <= '0;
        best         <= SCORE_MAX;
        found        <= 1'b0;
        opt_col      <= '0;
        opt_rotation <= '0;
      end
      if (sim_done) begin
        eval_board   <= sim_next_board;
        eval_cleared <= sim_cleared;
      end
      if (better) begin
        best         <= eval_score;
        opt_col      <= col;
        opt_rotation <= rot;
        found        <= 1'b1;
      end
      if (advance) begin
        if (!at_rot_last) begin
          rot <= rot + 2'd1;
        end else if (!at_col_last) begin
          col <= col + 1'b1;
          rot <= '0;
        end
      end
      if (state == RESP) begin
        opt_score <= best;
        opt_found <= found;
      end
    end
  end

  assign resp_from_client = (state == RESP);
  assign sim_request      = (state == SIM);
  assign eval_request     = (state == EVAL);
  assign sim_col          = col;
  assign sim_rotation     = rot;
  assign sim_block        = blk;
  assign sim_board        = board;

endmodule

// File: tb/tb_placement_search.sv
// Self-checking bench for placement_search: stub simulator/evaluator driven from
// candidate tables, fixed scenario vectors, a reset-abort sequence and random runs.
module tb_placement_search;

  localparam int COLS    = 10;
  localparam int ROWS    = 20;
  localparam int COL_W   = 4;
  localparam int CLR_W   = 10;
  localparam int SCORE_W = 64;
  localparam int BW      = ROWS * COLS;
  localparam longint SMAX = 64'sh7FFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT
  logic                      req_to_client = 1'b0;
  logic [3:0]                cur_block = '0;
  logic [BW-1:0]             cur_board = '0;
  logic                      resp_from_client;
  logic [COL_W-1:0]          opt_col;
  logic [1:0]                opt_rotation;
  logic                      opt_found;
  logic signed [SCORE_W-1:0] opt_score;
  logic                      sim_request;
  logic [COL_W-1:0]          sim_col;
  logic [1:0]                sim_rotation;
  logic [3:0]                sim_block;
  logic [BW-1:0]             sim_board;
  logic                      sim_ready;
  logic                      sim_valid;
  logic [BW-1:0]             sim_next_board;
  logic [CLR_W-1:0]          sim_cleared;
  logic                      eval_request;
  logic [BW-1:0]             eval_board;
  logic [CLR_W-1:0]          eval_cleared;
  logic                      eval_ready;
  logic signed [SCORE_W-1:0] eval_score;

  placement_search dut (
    .clk(clk), .rst(rst), .req_to_client(req_to_client), .cur_block(cur_block),
    .cur_board(cur_board), .resp_from_client(resp_from_client), .opt_col(opt_col),
    .opt_rotation(opt_rotation), .opt_found(opt_found), .opt_score(opt_score),
    .sim_request(sim_request), .sim_col(sim_col), .sim_rotation(sim_rotation),
    .sim_block(sim_block), .sim_board(sim_board), .sim_ready(sim_ready),
    .sim_valid(sim_valid), .sim_next_board(sim_next_board), .sim_cleared(sim_cleared),
    .eval_request(eval_request), .eval_board(eval_board), .eval_cleared(eval_cleared),
    .eval_ready(eval_ready), .eval_score(eval_score)
  );

  // second DUT without symmetry skipping, zero-wait stubs
  logic                      req_2 = 1'b0;
  logic [3:0]                cur_block_2 = '0;
  logic [BW-1:0]             cur_board_2 = '0;
  logic                      resp_2;
  logic [COL_W-1:0]          opt_col_2;
  logic [1:0]                opt_rotation_2;
  logic                      opt_found_2;
  logic signed [SCORE_W-1:0] opt_score_2;
  logic                      sim_request_2;
  logic [COL_W-1:0]          sim_col_2;
  logic [1:0]                sim_rotation_2;
  logic [3:0]                sim_block_2;
  logic [BW-1:0]             sim_board_2;
  logic                      eval_request_2;
  logic [BW-1:0]             eval_board_2;
  logic [CLR_W-1:0]          eval_cleared_2;

  placement_search #(.SKIP_SYMMETRIC(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .req_to_client(req_2), .cur_block(cur_block_2),
    .cur_board(cur_board_2), .resp_from_client(resp_2), .opt_col(opt_col_2),
    .opt_rotation(opt_rotation_2), .opt_found(opt_found_2), .opt_score(opt_score_2),
    .sim_request(sim_request_2), .sim_col(sim_col_2), .sim_rotation(sim_rotation_2),
    .sim_block(sim_block_2), .sim_board(sim_board_2), .sim_ready(sim_request_2),
    .sim_valid(1'b1), .sim_next_board(sim_board_2), .sim_cleared('0),
    .eval_request(eval_request_2), .eval_board(eval_board_2), .eval_cleared(eval_cleared_2),
    .eval_ready(eval_request_2), .eval_score(64'sd5)
  );

  // candidate tables indexed by col*4+rot
  bit     legal_tab[64];
  longint score_tab[64];
  int     clr_tab[64];
  bit     rand_dly = 1'b0;

  int sim_cnt = 0, eval_cnt = 0, sim_dly = 0, eval_dly = 0;
  logic [5:0] sim_idx;
  assign sim_idx        = {sim_col, sim_rotation};
  assign sim_ready      = sim_request && (!rand_dly || sim_cnt >= sim_dly);
  assign sim_valid      = legal_tab[sim_idx];
  assign sim_next_board = {sim_board[BW-1:6], sim_idx};
  assign sim_cleared    = clr_tab[sim_idx][CLR_W-1:0];
  assign eval_ready     = eval_request && (!rand_dly || eval_cnt >= eval_dly);
  assign eval_score     = score_tab[eval_board[5:0]] + longint'(eval_cleared);

  always @(posedge clk) begin
    if (sim_request && !sim_ready) sim_cnt <= sim_cnt + 1;
    else begin
      sim_cnt <= 0;
      if (sim_request) sim_dly <= int'($urandom_range(0, 3));
    end
    if (eval_request && !eval_ready) eval_cnt <= eval_cnt + 1;
    else begin
      eval_cnt <= 0;
      if (eval_request) eval_dly <= int'($urandom_range(0, 3));
    end
  end

  // cumulative event counters; runs take differences of snapshots
  logic [3:0]    exp_blk = '0;
  logic [BW-1:0] exp_board = '0;
  int sim_hs = 0, eval_hs = 0, rotnz_hs = 0, board_err = 0, resp_cnt = 0, sim_hs_2 = 0;
  always @(posedge clk) begin
    if (sim_request && sim_ready) begin
      sim_hs <= sim_hs + 1;
      if (sim_rotation != 2'd0) rotnz_hs <= rotnz_hs + 1;
      if (sim_board !== exp_board || sim_block !== exp_blk) board_err <= board_err + 1;
    end
    if (eval_request && eval_ready) eval_hs <= eval_hs + 1;
    if (resp_from_client) resp_cnt <= resp_cnt + 1;
    if (sim_request_2) sim_hs_2 <= sim_hs_2 + 1;
  end

  int total = 0, passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fill_tables(input int lm, input int sm);
    for (int i = 0; i < 64; i++) begin
      case (lm)
        0:       legal_tab[i] = 1'b1;
        1:       legal_tab[i] = (i == 3 * 4 + 1);
        default: legal_tab[i] = 1'b0;
      endcase
      case (sm)
        0:       score_tab[i] = longint'(i) + 100;
        1:       score_tab[i] = 7;
        2:       score_tab[i] = -5;
        default: score_tab[i] = 1000 - longint'(i);
      endcase
      clr_tab[i] = 0;
    end
  endtask

  // behavioural model: walk candidates in column-major order, keep first strict minimum
  task automatic model(input logic [3:0] b, output int mc, output int mr, output int mf,
                       output longint ms, output int me, output int msims,
                       output int mevals, output int mrnz);
    int nrot;
    longint s;
    mc = 0; mr = 0; mf = 0; ms = SMAX; me = 0; msims = 0; mevals = 0; mrnz = 0;
    if (b >= 4'd7) return;
    nrot = (b == 4'd1) ? 1 : ((b == 4'd0 || b == 4'd3 || b == 4'd4) ? 2 : 4);
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < nrot; r++) begin
        msims++;
        if (r != 0) mrnz++;
        if (legal_tab[c * 4 + r]) begin
          mevals++;
          me += 2;
          s = score_tab[c * 4 + r] + longint'(clr_tab[c * 4 + r]);
          if (s < ms) begin ms = s; mc = c; mr = r; mf = 1; end
        end else begin
          me += 1;
        end
      end
    end
  endtask

  task automatic start_and_wait(input string tag, input logic [3:0] b,
                                input logic [BW-1:0] brd, output int edges);
    @(negedge clk);
    cur_block = b; cur_board = brd; exp_blk = b; exp_board = brd; req_to_client = 1'b1;
    @(posedge clk); #1;
    req_to_client = 1'b0;
    edges = 0;
    while (!resp_from_client && edges < 3000) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, ".resp_seen"}, resp_from_client, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_and_check(input string tag, input logic [3:0] b, input bit chk_edges,
                               input int ec, input int er, input int ef, input longint es,
                               input int ee, input int esims, input int eevals, input int ernz);
    int s0, v0, z0, b0, p0, edges;
    logic [BW-1:0] brd;
    for (int k = 0; k < BW; k++) brd[k] = 1'($urandom_range(0, 1));
    s0 = sim_hs; v0 = eval_hs; z0 = rotnz_hs; b0 = board_err; p0 = resp_cnt;
    start_and_wait(tag, b, brd, edges);
    check({tag, ".opt_col"}, longint'(opt_col), ec);
    check({tag, ".opt_rotation"}, longint'(opt_rotation), er);
    check({tag, ".opt_found"}, longint'(opt_found), ef);
    check({tag, ".opt_score"}, opt_score, es);
    check({tag, ".sim_requests"}, sim_hs - s0, esims);
    check({tag, ".eval_requests"}, eval_hs - v0, eevals);
    check({tag, ".rot_nonzero"}, rotnz_hs - z0, ernz);
    check({tag, ".latched_board"}, board_err - b0, 0);
    check({tag, ".resp_cycles"}, resp_cnt - p0, 1);
    if (chk_edges) check({tag, ".resp_edge"}, edges, ee);
  endtask

  typedef struct {
    string      name;
    logic [3:0] blk;
    int         legal_mode;
    int         score_mode;
    int         exp_col;
    int         exp_rot;
    int         exp_found;
    longint     exp_score;
    int         exp_edges;
    int         exp_sims;
    int         exp_evals;
    int         exp_rotnz;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int mc, mr, mf, me, msims, mevals, mrnz, k;
    longint ms;
    logic [3:0] b;

    vecs[0] = '{"t_all_legal",   4'd2, 0, 0, 0, 0, 1, 100,  80, 40, 40, 30};
    vecs[1] = '{"o_skip_sym",    4'd1, 0, 0, 0, 0, 1, 100,  20, 10, 10, 0};
    vecs[2] = '{"i_one_legal",   4'd0, 1, 2, 3, 1, 1, -5,   21, 20, 1,  10};
    vecs[3] = '{"s_tie_first",   4'd3, 0, 1, 0, 0, 1, 7,    40, 20, 20, 10};
    vecs[4] = '{"invalid_block", 4'd9, 0, 0, 0, 0, 0, SMAX, 0,  0,  0,  0};
    vecs[5] = '{"l_none_legal",  4'd6, 2, 0, 0, 0, 0, SMAX, 40, 40, 0,  30};
    vecs[6] = '{"z_last_wins",   4'd4, 0, 3, 9, 1, 1, 963,  40, 20, 20, 10};

    fill_tables(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset.resp", resp_from_client, 0);
    check("reset.sim_request", sim_request, 0);
    check("reset.eval_request", eval_request, 0);
    check("reset.opt_score", opt_score, 0);
    check("reset.opt_found", opt_found, 0);
    check("reset.sim_board_zero", longint'(sim_board != '0), 0);
    check("reset.eval_board_zero", longint'(eval_board != '0), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      fill_tables(vecs[i].legal_mode, vecs[i].score_mode);
      run_and_check(vecs[i].name, vecs[i].blk, 1'b1, vecs[i].exp_col, vecs[i].exp_rot,
                    vecs[i].exp_found, vecs[i].exp_score, vecs[i].exp_edges,
                    vecs[i].exp_sims, vecs[i].exp_evals, vecs[i].exp_rotnz);
    end

    // O block without symmetry skipping tries all four rotations
    @(negedge clk);
    cur_block_2 = 4'd1; req_2 = 1'b1;
    @(posedge clk); #1;
    req_2 = 1'b0;
    k = 0;
    while (!resp_2 && k < 3000) begin @(posedge clk); #1; k++; end
    check("o_no_skip.resp_seen", resp_2, 1);
    @(posedge clk); #1;
    check("o_no_skip.sim_requests", sim_hs_2, 40);
    check("o_no_skip.opt_found", opt_found_2, 1);
    check("o_no_skip.opt_score", opt_score_2, 5);

    // reset in the middle of an evaluation handshake
    fill_tables(0, 0);
    rand_dly = 1'b1;
    @(negedge clk);
    cur_block = 4'd2; exp_blk = 4'd2; exp_board = cur_board; req_to_client = 1'b1;
    @(posedge clk); #1;
    req_to_client = 1'b0;
    repeat (3) @(posedge clk);
    k = 0;
    while (!eval_request && k < 200) begin @(posedge clk); #1; k++; end
    check("abort.reached_eval", eval_request, 1);
    k = resp_cnt;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.resp", resp_from_client, 0);
    check("abort.sim_request", sim_request, 0);
    check("abort.eval_request", eval_request, 0);
    check("abort.opt_found", opt_found, 0);
    check("abort.opt_score", opt_score, 0);
    check("abort.opt_col", opt_col, 0);
    check("abort.eval_board_zero", longint'(eval_board != '0), 0);
    repeat (5) @(posedge clk);
    #1;
    check("abort.no_pulse", resp_cnt - k, 0);
    check("abort.stays_idle", sim_request, 0);
    run_and_check("after_abort", vecs[0].blk, 1'b0, vecs[0].exp_col, vecs[0].exp_rot,
                  vecs[0].exp_found, vecs[0].exp_score, 0, vecs[0].exp_sims,
                  vecs[0].exp_evals, vecs[0].exp_rotnz);

    // randomized tables and delays against the model
    for (int it = 0; it < 14; it++) begin
      b = 4'($urandom_range(0, 7));
      rand_dly = 1'($urandom_range(0, 1));
      for (int i = 0; i < 64; i++) begin
        legal_tab[i] = ($urandom_range(0, 3) != 0);
        score_tab[i] = longint'($urandom_range(0, 40)) - 20;
        clr_tab[i]   = int'($urandom_range(0, 3));
      end
      model(b, mc, mr, mf, ms, me, msims, mevals, mrnz);
      run_and_check($sformatf("rand%0d", it), b, !rand_dly, mc, mr, mf, ms, me,
                    msims, mevals, mrnz);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/placement_search.md
# placement_search

Parametrised successor to the placement search controller. Given a board and a falling block, it sweeps every candidate (column, rotation) pair. For each candidate it asks an external simulator for the resulting board, and for each legal result it asks an external evaluator for a score. It reports the lowest-scoring legal placement to the main controller. The simulator and evaluator handshakes are exposed as ports, so either model can be swapped without editing this block. New relative to the previous generation:
- board size is generic;
- symmetric rotations can be skipped;
- illegal placements skip evaluation;
- a found flag and the best score are reported;
- unknown block codes are rejected.

## Interface
- COLS, 10, board width in cells
- ROWS, 20, board height in cells
- COL_W, 4, width of column indices (≥ clog2(COLS))
- CLR_W, 10, width of cleared-line count
- SCORE_W, 64, signed score width
- SKIP_SYMMETRIC, 1, 1 = use per-block rotation count; 0 = always try 4 rotations

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_to_client  in  1  start request, sampled in IDLE only
- cur_block  in  4  block code: 0=I 1=O 2=T 3=S 4=Z 5=J 6=L, 7–15 invalid
- cur_board  in  ROWS*COLS  board, row r at bits [COLS*r +: COLS]
- resp_from_client  out  1  one-cycle done pulse
- opt_col  out  COL_W  best column
- opt_rotation  out  2  best rotation
- opt_found  out  1  1 = at least one legal placement was found
- opt_score  out  SCORE_W  best score (signed)
- sim_request  out  1  simulator request
- sim_col  out  COL_W  candidate column
- sim_rotation  out  2  candidate rotation
- sim_block  out  4  latched block
- sim_board  out  ROWS*COLS  latched board
- sim_ready  in  1  simulator result valid
- sim_valid  in  1  candidate is legal
- sim_next_board  in  ROWS*COLS  resulting board
- sim_cleared  in  CLR_W  lines cleared by the placement
- eval_request  out  1  evaluator request
- eval_board  out  ROWS*COLS  captured next board
- eval_cleared  out  CLR_W  captured cleared count
- eval_ready  in  1  score valid
- eval_score  in  SCORE_W  signed score (lower is better)

## Operation
States: IDLE, SIM, EVAL, RESP. sim_request = (state==SIM) and eval_request = (state==EVAL), both Moore decodes.

- **IDLE**
  - On req_to_client=1: latch cur_board and cur_block; col←0, rot←0, best←max positive SCORE_W, found←0.
  - Valid block → SIM. Invalid block (≥7) → RESP, with opt_found=0, opt_col=0, opt_rotation=0, opt_score=max positive.
- **SIM**
  - Hold the request until sim_ready=1.
  - On that edge: capture sim_next_board and sim_cleared into eval_board and eval_cleared.
  - sim_valid=1 → EVAL. sim_valid=0 → advance to the next candidate.
- **EVAL**
  - Hold the request until eval_ready=1.
  - On that edge, if eval_score < best (signed, strict): best←eval_score, opt_col←col, opt_rotation←rot, found←1. Then advance.
- **Advance** (same edge as the completing handshake)
  - NROT = 1 for O; 2 for I, S, Z; 4 for T, J, L. NROT = 4 for every block when SKIP_SYMMETRIC=0.
  - If rot==NROT-1 and col==COLS-1 → RESP.
  - Else if rot==NROT-1: col←col+1, rot←0 → SIM.
  - Else: rot←rot+1 → SIM.
- **RESP**
  - resp_from_client=1 for exactly one cycle; opt_score←best, opt_found←found. → IDLE.
- Candidate order is column-major, rotation-minor. On equal scores the first candidate in this order is kept.
- All columns 0..COLS-1 are tried; legality is decided only by the simulator.
- sim_ready is ignored outside SIM and eval_ready is ignored outside EVAL. req_to_client is ignored outside IDLE.
- opt_* hold their values from the end of RESP until the next accepted request.

## Timing
- Reset values: state=IDLE; all outputs 0, including opt_score=0, sim_board=0 and eval_board=0.
- rst asserted mid-search aborts the search immediately: no response pulse is issued and no results are kept.
- A handshake phase lasts 1 + (cycles before ready) cycles. If ready is asserted combinationally in the first request cycle, the phase takes 1 cycle.
- With zero-wait submodules: accept edge E0; each legal candidate costs 2 edges and each illegal candidate 1 edge. resp_from_client is high in the cycle after the last candidate's completing edge.
  - Example: T block, COLS=10, all legal: 40 candidates, resp high in the cycle following edge E0+80.
- The request deasserts on the edge that samples ready. The next request of the other kind is high in the following cycle.
- req_to_client held high continuously starts a new search on the edge after RESP.

## Test plan
- Reset, then T block, empty 10×20 board, zero-wait stubs; score = col*4+rot+100 → opt_col=0, opt_rotation=0, opt_found=1, opt_score=100, pulse after edge E0+80.
- O block with SKIP_SYMMETRIC=1 → exactly 10 sim requests, rot always 0. With SKIP_SYMMETRIC=0 → 40 sim requests.
- I block; sim_valid=0 except (col 3, rot 1); score −5 → opt_col=3, opt_rotation=1, opt_score=−5, exactly 1 eval request, pulse after edge E0+21.
- Every candidate scores 7 → first candidate wins: opt_col=0, opt_rotation=0.
- cur_block=9 → resp pulse on the second edge after accept, opt_found=0, no sim requests.
- Random 0–3 cycle ready delays, with rst asserted mid-EVAL → state IDLE, no pulse, outputs 0. A following request completes normally with a result identical to the zero-wait run.
